// File: rtl/axi_req_flit_packer.sv
// Packs one request FLIT per cycle into FPW-FLIT AXI4-Stream beats with per-slot
// valid/header/tail flags in TUSER, and flags request framing violations.
module axi_req_flit_packer #(
    parameter int unsigned FPW = 2
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 flit_valid,
    output logic                 flit_ready,
    input  logic [127:0]         flit_data,
    input  logic                 flit_hdr,
    input  logic                 flit_tail,
    output logic                 TVALID,
    input  logic                 TREADY,
    output logic [FPW*128-1:0]   TDATA,
    output logic [FPW*16-1:0]    TUSER,
    output logic                 proto_err
);

    localparam int unsigned FW = 128;
    localparam int unsigned DW = FPW * FW;
    localparam int unsigned UW = FPW * 16;
    localparam int unsigned CW = $clog2(FPW);

    typedef enum logic {
        IDLE,
        IN_PKT
    } state_t;

    state_t            state_q, state_d;
    logic              err_d;

    logic [DW-1:0]     acc_data, ins_data, out_data;
    logic [FPW-1:0]    acc_v, acc_h, acc_t;
    logic [FPW-1:0]    ins_v, ins_h, ins_t;
    logic [FPW-1:0]    out_v, out_h, out_t;
    logic [CW-1:0]     cnt, wr_slot;
    logic              acc_done;
    logic              out_free, take, comp, load_out;

    assign out_free   = !TVALID || TREADY;
    assign flit_ready = !acc_done || out_free || !res_n;
    assign take       = flit_valid && flit_ready;
    // A held complete beat is drained this edge whenever out_free, so new FLITs restart at slot 0
    assign wr_slot    = acc_done ? '0 : cnt;
    assign comp       = take && (flit_tail || (wr_slot == CW'(FPW - 1)));
    assign load_out   = out_free && (acc_done || comp);

    // Accumulator contents with the incoming FLIT inserted at its slot
    always_comb begin
        ins_data = acc_done ? '0 : acc_data;
        ins_v    = acc_done ? '0 : acc_v;
        ins_h    = acc_done ? '0 : acc_h;
        ins_t    = acc_done ? '0 : acc_t;
        for (int unsigned i = 0; i < FPW; i++) begin
            if (take && (wr_slot == CW'(i))) begin
                ins_data[i*FW +: FW] = flit_data;
                ins_v[i]             = 1'b1;
                ins_h[i]             = flit_hdr;
                ins_t[i]             = flit_tail;
            end
        end
        out_data = acc_done ? acc_data : ins_data;
        out_v    = acc_done ? acc_v    : ins_v;
        out_h    = acc_done ? acc_h    : ins_h;
        out_t    = acc_done ? acc_t    : ins_t;
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            TVALID   <= 1'b0;
            TDATA    <= '0;
            TUSER    <= '0;
            acc_data <= '0;
            acc_v    <= '0;
            acc_h    <= '0;
            acc_t    <= '0;
            cnt      <= '0;
            acc_done <= 1'b0;
        end else begin
            if (load_out) begin
                TVALID <= 1'b1;
                TDATA  <= out_data;
                TUSER  <= {{(UW - 3*FPW){1'b0}}, out_t, out_h, out_v};
            end else if (out_free) begin
                TVALID <= 1'b0;
            end

            if (acc_done) begin
                if (out_free) begin
                    acc_data <= ins_data;
                    acc_v    <= ins_v;
                    acc_h    <= ins_h;
                    acc_t    <= ins_t;
                    acc_done <= comp;
                    cnt      <= (take && !comp) ? CW'(1) : '0;
                end
            end else if (comp) begin
                // Bypass straight to the output register when it is free
                acc_data <= out_free ? '0 : ins_data;
                acc_v    <= out_free ? '0 : ins_v;
                acc_h    <= out_free ? '0 : ins_h;
                acc_t    <= out_free ? '0 : ins_t;
                acc_done <= !out_free;
                cnt      <= '0;
            end else if (take) begin
                acc_data <= ins_data;
                acc_v    <= ins_v;
                acc_h    <= ins_h;
                acc_t    <= ins_t;
                cnt      <= cnt + CW'(1);
            end
        end
    end

    // Framing checker: header opens a packet, tail closes it
    always_comb begin
        state_d = state_q;
        err_d   = proto_err;
        if (take) begin
            case (state_q)
                IDLE: begin
                    if (!flit_hdr)
                        err_d = 1'b1;
                    else if (!flit_tail)
                        state_d = IN_PKT;
                end
                IN_PKT: begin
                    if (flit_hdr)
                        err_d = 1'b1;
                    if (flit_tail)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q   <= IDLE;
            proto_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            proto_err <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_req_flit_packer.sv
// Bench for axi_req_flit_packer: directed FPW=2 scenarios plus randomized FPW=4
// traffic checked against a packet-level beat model.
module tb_axi_req_flit_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         res_n;
    logic         fv2, fr2, fh2, ft2, tv2, tr2, pe2;
    logic [127:0] fd2;
    logic [255:0] td2;
    logic [31:0]  tu2;
    logic         fv4, fr4, fh4, ft4, tv4, tr4, pe4;
    logic [127:0] fd4;
    logic [511:0] td4;
    logic [63:0]  tu4;

    axi_req_flit_packer #(.FPW(2)) dut2 (
        .clk(clk), .res_n(res_n), .flit_valid(fv2), .flit_ready(fr2), .flit_data(fd2),
        .flit_hdr(fh2), .flit_tail(ft2), .TVALID(tv2), .TREADY(tr2), .TDATA(td2),
        .TUSER(tu2), .proto_err(pe2)
    );

    axi_req_flit_packer #(.FPW(4)) dut4 (
        .clk(clk), .res_n(res_n), .flit_valid(fv4), .flit_ready(fr4), .flit_data(fd4),
        .flit_hdr(fh4), .flit_tail(ft4), .TVALID(tv4), .TREADY(tr4), .TDATA(td4),
        .TUSER(tu4), .proto_err(pe4)
    );

    int vecs = 0;
    int errs = 0;

    // Reference model: queue of complete beats awaiting output handshake, plus a partial beat
    logic [511:0] bq_d [2][4];
    logic [63:0]  bq_u [2][4];
    int           bq_n [2];
    logic [511:0] pd [2];
    logic [7:0]   pv [2];
    logic [7:0]   ph [2];
    logic [7:0]   pt [2];
    int           pc [2];
    bit           mpe [2];
    bit           min_pkt [2];
    bit           acc_now [2];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_partial(input int d);
        pd[d] = '0;
        pv[d] = '0;
        ph[d] = '0;
        pt[d] = '0;
        pc[d] = 0;
    endtask

    task automatic model_reset(input int d);
        bq_n[d]    = 0;
        mpe[d]     = 1'b0;
        min_pkt[d] = 1'b0;
        acc_now[d] = 1'b0;
        clear_partial(d);
    endtask

    task automatic observe(input int d, input logic fv, input logic fr, input logic fh,
                           input logic ft, input logic [127:0] fd, input logic tv,
                           input logic tr, input logic [511:0] td, input logic [63:0] tu,
                           input logic pe);
        int f;
        logic [63:0] u;
        f = (d == 0) ? 2 : 4;
        chk(d == 0 ? "tvalid2" : "tvalid4", 512'(tv), 512'(bq_n[d] > 0));
        chk(d == 0 ? "flit_ready2" : "flit_ready4", 512'(fr),
            512'(!res_n || !(bq_n[d] >= 2 && !tr)));
        chk(d == 0 ? "proto_err2" : "proto_err4", 512'(pe), 512'(mpe[d]));
        if (tv && bq_n[d] > 0) begin
            chk(d == 0 ? "tdata2" : "tdata4", td, bq_d[d][0]);
            chk(d == 0 ? "tuser2" : "tuser4", 512'(tu), 512'(bq_u[d][0]));
        end
        acc_now[d] = 1'b0;
        if (!res_n) begin
            model_reset(d);
            return;
        end
        if (tv && tr && bq_n[d] > 0) begin
            for (int i = 0; i < 3; i++) begin
                bq_d[d][i] = bq_d[d][i+1];
                bq_u[d][i] = bq_u[d][i+1];
            end
            bq_n[d]--;
        end
        if (fv && fr) begin
            acc_now[d] = 1'b1;
            if (!min_pkt[d]) begin
                if (!fh) mpe[d] = 1'b1;
                else if (!ft) min_pkt[d] = 1'b1;
            end else begin
                if (fh) mpe[d] = 1'b1;
                if (ft) min_pkt[d] = 1'b0;
            end
            pd[d][pc[d]*128 +: 128] = fd;
            pv[d][pc[d]] = 1'b1;
            ph[d][pc[d]] = fh;
            pt[d][pc[d]] = ft;
            pc[d]++;
            if (pc[d] == f || ft) begin
                u = 64'(pv[d]) | (64'(ph[d]) << f) | (64'(pt[d]) << (2*f));
                chk("beats_outstanding", 512'(bq_n[d] < 3), 512'(1));
                if (bq_n[d] < 4) begin
                    bq_d[d][bq_n[d]] = pd[d];
                    bq_u[d][bq_n[d]] = u;
                    bq_n[d]++;
                end
                clear_partial(d);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe(0, fv2, fr2, fh2, ft2, fd2, tv2, tr2, 512'(td2), 64'(tu2), pe2);
        observe(1, fv4, fr4, fh4, ft4, fd4, tv4, tr4, td4, tu4, pe4);
        @(posedge clk);
        #1;
    endtask

    // Offer one FLIT until accepted; rnd randomizes valid gaps and TREADY
    task automatic send(input int d, input bit rnd, input logic hdr, input logic tail,
                        input logic [127:0] data, output int cycles);
        cycles = 0;
        for (int n = 0; n < 200; n++) begin
            if (d == 0) begin
                fv2 = rnd ? (($urandom % 4) != 0) : 1'b1;
                fh2 = hdr; ft2 = tail; fd2 = data;
                if (rnd) tr2 = (($urandom % 4) != 0);
            end else begin
                fv4 = rnd ? (($urandom % 4) != 0) : 1'b1;
                fh4 = hdr; ft4 = tail; fd4 = data;
                if (rnd) tr4 = (($urandom % 4) != 0);
            end
            tick();
            cycles++;
            if (acc_now[d]) break;
        end
        chk("send_accepted", 512'(acc_now[d]), 512'(1));
    endtask

    logic [127:0] fa, fb, fc, fx, fy;
    int           cyc, idx, total;

    initial begin
        res_n = 1'b0;
        fv2 = 1'b0; fh2 = 1'b0; ft2 = 1'b0; fd2 = '0; tr2 = 1'b1;
        fv4 = 1'b0; fh4 = 1'b0; ft4 = 1'b0; fd4 = '0; tr4 = 1'b1;
        model_reset(0);
        model_reset(1);
        @(posedge clk);
        #1;
        tick();
        chk("rst_tvalid", 512'(tv2), 512'(0));
        chk("rst_tuser", 512'(tu2), 512'(0));
        chk("rst_tdata", 512'(td2), 512'(0));
        chk("rst_proto_err", 512'(pe2), 512'(0));
        chk("rst_flit_ready", 512'(fr2), 512'(1));
        res_n = 1'b1;
        tick();

        // Three-FLIT packet, sink always ready
        fa = {4{32'hAAAA_0001}};
        fb = {4{32'hBBBB_0002}};
        fc = {4{32'hCCCC_0003}};
        send(0, 1'b0, 1'b1, 1'b0, fa, cyc);
        chk("abc_no_beat_yet", 512'(tv2), 512'(0));
        send(0, 1'b0, 1'b0, 1'b0, fb, cyc);
        chk("abc_beat1_valid", 512'(tv2), 512'(1));
        chk("abc_beat1_tuser", 512'(tu2), 512'(32'h07));
        chk("abc_beat1_tdata", 512'(td2), 512'({fb, fa}));
        chk("abc_ready", 512'(fr2), 512'(1));
        send(0, 1'b0, 1'b0, 1'b1, fc, cyc);
        chk("abc_beat2_valid", 512'(tv2), 512'(1));
        chk("abc_beat2_tuser", 512'(tu2), 512'(32'h11));
        chk("abc_beat2_tdata", 512'(td2), 512'({128'd0, fc}));
        fv2 = 1'b0;
        tick();
        chk("abc_idle", 512'(tv2), 512'(0));

        // Single-FLIT packet
        fx = {16{8'h5A}};
        send(0, 1'b0, 1'b1, 1'b1, fx, cyc);
        chk("single_tuser", 512'(tu2), 512'(32'h15));
        chk("single_tdata", 512'(td2), 512'({128'd0, fx}));
        fv2 = 1'b0;
        tick();

        // Back-pressure: only two beats may be held
        tr2 = 1'b0;
        idx = 0;
        for (int n = 0; n < 9; n++) begin
            fv2 = (idx < 7); fh2 = (idx == 0); ft2 = 1'b0; fd2 = 128'(idx + 100);
            tick();
            if (acc_now[0]) idx++;
        end
        chk("bp_accepted", 512'(idx), 512'(4));
        chk("bp_ready_low", 512'(fr2), 512'(0));
        chk("bp_tvalid", 512'(tv2), 512'(1));
        chk("bp_tdata_first", 512'(td2), 512'({128'd101, 128'd100}));
        tr2 = 1'b1;
        for (int n = 0; n < 40 && idx < 8; n++) begin
            fv2 = 1'b1; fh2 = 1'b0; ft2 = (idx == 7); fd2 = 128'(idx + 100);
            tick();
            if (acc_now[0]) idx++;
        end
        chk("bp_all_sent", 512'(idx), 512'(8));
        fv2 = 1'b0;
        tick();
        tick();
        chk("bp_drained", 512'(tv2), 512'(0));
        chk("bp_no_err", 512'(pe2), 512'(0));

        // Header without tail followed by another header
        send(0, 1'b0, 1'b1, 1'b0, fa, cyc);
        chk("err_before", 512'(pe2), 512'(0));
        send(0, 1'b0, 1'b1, 1'b0, fb, cyc);
        chk("err_set", 512'(pe2), 512'(1));
        chk("err_beat_tdata", 512'(td2), 512'({fb, fa}));
        send(0, 1'b0, 1'b0, 1'b1, fc, cyc);
        fv2 = 1'b0;
        tick();
        chk("err_sticky", 512'(pe2), 512'(1));

        // Reset with a held beat and a partial accumulator
        tr2 = 1'b0;
        send(0, 1'b0, 1'b1, 1'b1, fx, cyc);
        fy = {4{32'h1234_5678}};
        send(0, 1'b0, 1'b1, 1'b0, fy, cyc);
        fv2 = 1'b0;
        chk("pre_rst_tvalid", 512'(tv2), 512'(1));
        res_n = 1'b0;
        tick();
        chk("mid_rst_tvalid", 512'(tv2), 512'(0));
        chk("mid_rst_tuser", 512'(tu2), 512'(0));
        chk("mid_rst_proto_err", 512'(pe2), 512'(0));
        res_n = 1'b1;
        tr2 = 1'b1;
        send(0, 1'b0, 1'b1, 1'b0, fa, cyc);
        send(0, 1'b0, 1'b0, 1'b1, fb, cyc);
        chk("post_rst_tuser", 512'(tu2), 512'(32'h27));
        chk("post_rst_tdata", 512'(td2), 512'({fb, fa}));
        fv2 = 1'b0;
        tick();

        // FPW=4 throughput with sink always ready
        total = 0;
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 5; k++) begin
                send(1, 1'b0, k == 0, k == 4, {4{$urandom}}, cyc);
                total += cyc;
            end
        chk("throughput4", 512'(total), 512'(15));

        // FPW=4 randomized packets
        for (int p = 0; p < 1000; p++) begin
            int len;
            len = 1 + int'($urandom % 9);
            for (int k = 0; k < len; k++)
                send(1, 1'b1, k == 0, k == len - 1, {$urandom, $urandom, $urandom, $urandom}, cyc);
        end
        fv4 = 1'b0;
        tr4 = 1'b1;
        for (int n = 0; n < 6; n++) tick();
        chk("rand_drained", 512'(tv4), 512'(0));
        chk("rand_no_err", 512'(pe4), 512'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/axi_req_flit_packer.md
# axi_req_flit_packer

Packs a single-FLIT-per-cycle request stream into FPW-FLIT-wide AXI4-Stream beats carrying per-slot valid, header and tail flags in TUSER. It is the stage directly upstream of the AXI request interface of the HMC controller and drives its TVALID, TDATA and TUSER while consuming TREADY. It also checks request framing: a packet starts with a header FLIT and ends with a tail FLIT.

## Interface
- FPW, 2: FLITs per AXI beat (legal values 2, 4, 6, 8); DWIDTH = FPW*128, TUSER width = FPW*16.
- clk  in  1  single clock; all logic on rising edge.
- res_n  in  1  synchronous, active-low reset.
- flit_valid  in  1  input FLIT present.
- flit_ready  out  1  input FLIT accepted when flit_valid && flit_ready at a rising edge.
- flit_data  in  128  FLIT payload.
- flit_hdr  in  1  FLIT is a packet header.
- flit_tail  in  1  FLIT is a packet tail; hdr and tail together marks a 1-FLIT packet.
- TVALID  out  1  AXI beat valid.
- TREADY  in  1  AXI sink ready.
- TDATA  out  FPW*128  slot i occupies bits [128*i+127:128*i].
- TUSER  out  FPW*16  [FPW-1:0] Valid, [2FPW-1:FPW] Hdr, [3FPW-1:2FPW] Tail, remaining bits 0.
- proto_err  out  1  sticky framing error.

## Operation
- Accumulator: FPW slots, fill count cnt (0..FPW-1), flag acc_done (complete beat waiting).
- out_free = !TVALID || TREADY.
- flit_ready = !acc_done || out_free (combinational path from TREADY is intended).
- A FLIT accepted into slot cnt writes data and sets Valid[cnt]; Hdr[cnt] = flit_hdr, Tail[cnt] = flit_tail.
- A beat is complete when the accepted FLIT lands in slot FPW-1 or carries flit_tail. A tail always flushes a partial beat, so no beat holds FLITs from two packets.
- Edge behaviour, in priority order:
  - acc_done && out_free: the output register loads the accumulator and the accumulator clears. An accepted FLIT goes to slot 0 of the cleared accumulator. If that FLIT completes the beat, acc_done = 1 and cnt = 0; otherwise acc_done = 0 and cnt = 1.
  - !acc_done with a completing FLIT accepted: if out_free, the output register loads accumulator plus the new FLIT in the same edge (bypass), the accumulator clears and cnt = 0. If not out_free, acc_done = 1.
  - !acc_done with a non-completing FLIT accepted: cnt increments.
  - acc_done && !out_free: everything holds; flit_ready = 0.
- If out_free and nothing loads, TVALID goes to 0.
- While TVALID && !TREADY, TDATA and TUSER are held stable.
- Unused slots of an emitted beat have zero data and zero flags.
- Framing FSM with states IDLE and IN_PKT, updated on accepted FLITs only:
  - IDLE + hdr&&!tail → IN_PKT; IDLE + hdr&&tail → IDLE; IDLE + !hdr → proto_err.
  - IN_PKT + hdr → proto_err; IN_PKT + tail → IDLE.
  - The offending FLIT is still packed. proto_err stays set until reset.

## Timing
- Reset (res_n low at an edge): TVALID = 0, TDATA = 0, TUSER = 0, proto_err = 0, cnt = 0, acc_done = 0, FSM = IDLE. flit_ready = 1 during and after reset.
- Reset mid-packet discards both the accumulator and the output beat with no flush.
- Latency: a FLIT completing a beat at edge N makes TVALID = 1 after edge N if out_free held at N.
- Throughput: one FLIT per cycle sustained while TREADY = 1, with no bubbles for any FPW.
- Back-pressure: at most one complete beat is buffered beyond the output register. flit_ready falls only with acc_done && !TREADY && TVALID.

## Test plan
- FPW=2, TREADY=1, hdr FLIT A then data FLIT B then tail FLIT C, back-to-back → beat 1 {A,B} with TUSER[5:0]=6'b00_01_11. Beat 2 {C,0} with TUSER[5:0]=6'b01_00_01. TVALID one cycle after each completing FLIT. flit_ready constant 1.
- FPW=2, single-FLIT packet (hdr=tail=1) data 0x5A… → one beat with Valid=01, Hdr=01, Tail=01 and slot 1 zero.
- FPW=2, TREADY=0 held, 6 non-tail FLITs offered after a header → 4 FLITs accepted (one beat in the output register, one in acc_done), then flit_ready=0. Raising TREADY drains the beats in order with no loss or duplication and TDATA stable while stalled.
- Header, then a second header without a tail → proto_err=1 one edge after the second header, stays 1, and both FLITs are still emitted.
- Reset asserted with one FLIT in the accumulator and TVALID=1 → after the edge TVALID=0, TUSER=0, proto_err=0. The next hdr FLIT is packed into slot 0.
- FPW=4, random valid gaps and random TREADY, 1000 packets of 1–9 FLITs → scoreboard matches FLIT order, flags and beat boundaries, and proto_err stays 0.
